// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Purpose  : Shared types and configuration helper for the pipelined
//            add/subtract unit.
// Revision : 1.0  initial release
// ============================================================================
package addsub_pkg;

  // Operation select as seen on the op_sub input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  // Flags travelling with each operation through the pipeline. Inside the
  // pipe, carry is the carry out of the most recently completed slice and
  // zero is the running AND of the completed slices' zero terms.
  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } addsub_flags_t;

  localparam int MAX_STAGES = 4;

  // True when the width/depth pair can be split into equal slices.
  function automatic bit addsub_cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= MAX_STAGES) &&
           (width > 0) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_stage.sv
`default_nettype none
// ============================================================================
// Module   : addsub_stage
// Purpose  : One pipeline stage: adds operand slice IDX with the carry from
//            the previous stage, forwards the untouched operand slices and the
//            already completed result slices, and holds one valid bit.
// Revision : 1.0  initial release
// ============================================================================
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SW    = 32,
  parameter int IDX   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  input  logic [WIDTH-1:0]  prev_a,
  input  logic [WIDTH-1:0]  prev_b,
  input  logic [WIDTH-1:0]  prev_sum,
  input  addsub_flags_t     prev_flags,
  input  logic              next_ready,
  output logic              stage_valid,
  output logic [WIDTH-1:0]  stage_a,
  output logic [WIDTH-1:0]  stage_b,
  output logic [WIDTH-1:0]  stage_sum,
  output addsub_flags_t     stage_flags
);

  localparam int LO = IDX * SW;

  logic [SW:0]      slice_add;
  logic             carry_msb;
  logic [WIDTH-1:0] sum_next;
  addsub_flags_t    flags_next;
  logic             advance;
  logic             unused_prev_ovf;

  // Overflow from an earlier slice has no meaning for this one.
  assign unused_prev_ovf = prev_flags.overflow;

  // The stage may take a new entry when it is empty or its content leaves.
  assign advance = !stage_valid || next_ready;

  // Slice adder, result-slice merge and flag update for this stage.
  always_comb begin
    slice_add = {1'b0, prev_a[LO +: SW]} + {1'b0, prev_b[LO +: SW]}
              + {{SW{1'b0}}, prev_flags.carry};
    // Carry into the slice's top bit, recovered from the sum bit.
    carry_msb = prev_a[LO+SW-1] ^ prev_b[LO+SW-1] ^ slice_add[SW-1];
    sum_next = prev_sum;
    sum_next[LO +: SW] = slice_add[SW-1:0];
    flags_next.carry    = slice_add[SW];
    flags_next.overflow = carry_msb ^ slice_add[SW];
    flags_next.zero     = prev_flags.zero && (slice_add[SW-1:0] == '0);
  end

  // Valid bit: follows the upstream valid whenever the stage advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
    end else if (advance) begin
      stage_valid <= prev_valid;
    end
  end

  // Data registers: loaded only on a real transfer so idle outputs hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_a     <= '0;
      stage_b     <= '0;
      stage_sum   <= '0;
      stage_flags <= '0;
    end else if (advance && prev_valid) begin
      stage_a     <= prev_a;
      stage_b     <= prev_b;
      stage_sum   <= sum_next;
      stage_flags <= flags_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pipe
// Purpose  : Parametrised pipelined add/subtract unit with carry, overflow
//            and zero flags and valid/ready handshaking on both sides.
// Revision : 1.0  initial release
// ============================================================================
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  sum,
  output logic              carry,
  output logic              overflow,
  output logic              zero
);

  localparam int SW = WIDTH / STAGES;

  if (!addsub_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("addsub_pipe: WIDTH must be a multiple of STAGES and STAGES in 1..4");
  end

  // Index 0 is the input side, index k+1 is the output of stage k.
  logic [STAGES:0]  valid_c;
  logic [STAGES:0]  ready_c;
  logic [WIDTH-1:0] a_c    [0:STAGES];
  logic [WIDTH-1:0] b_c    [0:STAGES];
  logic [WIDTH-1:0] sum_c  [0:STAGES];
  addsub_flags_t    flags_c[0:STAGES];
  logic             is_sub;
  logic             unused_tail;

  // Subtraction is a + ~b + 1: invert b here, carry-in comes from op_sub.
  assign is_sub     = (addsub_op_e'(op_sub) == OP_SUB);
  assign valid_c[0] = in_valid;
  assign a_c[0]     = a;
  assign b_c[0]     = b ^ {WIDTH{is_sub}};
  assign sum_c[0]   = '0;
  assign flags_c[0] = '{carry: is_sub, overflow: 1'b0, zero: 1'b1};

  // Operand copies leaving the last stage have no further consumer.
  assign unused_tail = ^{a_c[STAGES], b_c[STAGES]};

  assign ready_c[STAGES] = out_ready;
  assign in_ready        = ready_c[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Ready chain !valid_k | ready_{k+1}, unrolled into prefix form: stage k
    // can move unless it and every stage after it are full and blocked.
    assign ready_c[k] = out_ready || !(&valid_c[STAGES:k+1]);

    addsub_stage #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .IDX   (k)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .prev_valid  (valid_c[k]),
      .prev_a      (a_c[k]),
      .prev_b      (b_c[k]),
      .prev_sum    (sum_c[k]),
      .prev_flags  (flags_c[k]),
      .next_ready  (ready_c[k+1]),
      .stage_valid (valid_c[k+1]),
      .stage_a     (a_c[k+1]),
      .stage_b     (b_c[k+1]),
      .stage_sum   (sum_c[k+1]),
      .stage_flags (flags_c[k+1])
    );
  end

  // The last stage holds the finished result and its final flags.
  assign out_valid = valid_c[STAGES];
  assign sum       = sum_c[STAGES];
  assign carry     = flags_c[STAGES].carry;
  assign overflow  = flags_c[STAGES].overflow;
  assign zero      = flags_c[STAGES].zero;

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_addsub_pipe
// Purpose  : Directed self-checking bench for addsub_pipe (64/2, 32/1, 32/4).
// Revision : 1.0  initial release
// ============================================================================
module tb_addsub_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 64-bit, 2-stage instance
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic        carry, overflow, zero;
  logic [63:0] a, b, sum;

  // 32-bit, 1-stage instance
  logic        v1_in, r1_in, v1_out, c1, o1, z1;
  logic [31:0] a1, b1, s1;

  // 32-bit, 4-stage instance
  logic        v4_in, r4_in, v4_out, c4, o4, z4;
  logic [31:0] a4, b4, s4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  addsub_pipe #(.WIDTH(64), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry),
    .overflow(overflow), .zero(zero));

  addsub_pipe #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1_in), .in_ready(r1_in),
    .op_sub(1'b0), .a(a1), .b(b1), .out_valid(v1_out),
    .out_ready(1'b1), .sum(s1), .carry(c1), .overflow(o1), .zero(z1));

  addsub_pipe #(.WIDTH(32), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4_in), .in_ready(r4_in),
    .op_sub(1'b0), .a(a4), .b(b4), .out_valid(v4_out),
    .out_ready(1'b1), .sum(s4), .carry(c4), .overflow(o4), .zero(z4));

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One operation on the 2-stage unit with an idle pipe and out_ready high.
  task automatic run_single(input string tag, input logic sub,
                            input logic [63:0] av, input logic [63:0] bv,
                            input logic [63:0] es, input logic ec,
                            input logic ev, input logic ez);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_sub    = sub;
    a         = av;
    b         = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_lat_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_sum"},   sum, es);
    check_eq({tag, "_flags"}, 64'({carry, overflow, zero}), 64'({ec, ev, ez}));
    @(posedge clk); #1;
  endtask

  logic [63:0] ea [0:7];
  logic [63:0] eb [0:7];
  logic [63:0] es [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sent, got, inflight, in_x, out_x, idx, lat, seen;
    rst = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    v1_in = 1'b0; a1 = '0; b1 = '0; v4_in = 1'b0; a4 = '0; b4 = '0;
    #2 rst = 1'b1;
    #2;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_sum", sum, 64'd0);
    check_eq("rst_flags", 64'({carry, overflow, zero}), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_valid_1_4", 64'({v1_out, v4_out}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: sum, carry, overflow, zero
    run_single("add_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
               64'h0, 1'b1, 1'b0, 1'b1);
    run_single("sub_5_7", 1'b1, 64'd5, 64'd7,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_single("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run_single("sub_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'h1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_single("sub_eq", 1'b1, 64'd7, 64'd7, 64'h0, 1'b1, 1'b0, 1'b1);
    run_single("upper_nz", 1'b0, 64'h0000_0001_0000_0000, 64'h0,
               64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);

    // Backpressure: 8 ops back-to-back, out_ready low for cycles 3..7
    ea[0] = 64'h0000_0000_0000_0001; eb[0] = 64'h0000_0000_0000_0002; es[0] = 64'h0000_0000_0000_0003;
    ea[1] = 64'h0000_0000_FFFF_FFFF; eb[1] = 64'h0000_0000_0000_0001; es[1] = 64'h0000_0001_0000_0000;
    ea[2] = 64'h1111_1111_1111_1111; eb[2] = 64'h2222_2222_2222_2222; es[2] = 64'h3333_3333_3333_3333;
    ea[3] = 64'h0123_4567_89AB_CDEF; eb[3] = 64'h1000_0000_0000_0000; es[3] = 64'h1123_4567_89AB_CDEF;
    ea[4] = 64'h0000_0000_0000_00FF; eb[4] = 64'h0000_0000_0000_0F00; es[4] = 64'h0000_0000_0000_0FFF;
    ea[5] = 64'hA000_0000_0000_0000; eb[5] = 64'h0500_0000_0000_0005; es[5] = 64'hA500_0000_0000_0005;
    ea[6] = 64'h0000_0001_8000_0000; eb[6] = 64'h0000_0000_8000_0000; es[6] = 64'h0000_0002_0000_0000;
    ea[7] = 64'h0000_0000_0000_0010; eb[7] = 64'h0000_0000_0000_0020; es[7] = 64'h0000_0000_0000_0030;
    sent = 0; got = 0; inflight = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      out_ready = (c < 3) || (c >= 8);
      idx       = (sent < 8) ? sent : 7;
      in_valid  = (sent < 8);
      op_sub    = 1'b0;
      a         = ea[idx];
      b         = eb[idx];
      @(negedge clk);
      check_eq("bp_in_ready", 64'(in_ready), 64'(!(inflight == 2 && !out_ready)));
      if (c >= 8) check_eq("bp_no_gap", 64'(out_valid), 64'd1);
      in_x  = (in_valid && in_ready) ? 1 : 0;
      out_x = (out_valid && out_ready) ? 1 : 0;
      if (out_x == 1) begin
        check_eq("bp_data", sum, es[got]);
        got++;
      end
      @(posedge clk); #1;
      sent     += in_x;
      inflight += in_x - out_x;
    end
    in_valid = 1'b0;
    check_eq("bp_count", 64'(got), 64'd8);
    @(posedge clk); #1;

    // Reset with two operations held in the pipe
    out_ready = 1'b0;
    in_valid  = 1'b1; op_sub = 1'b0;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("pre_rst_full", 64'({out_valid, in_ready}), 64'b10);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_sum_flags", {sum[60:0], carry, overflow, zero}, 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("rst_no_result", 64'(seen), 64'd0);
    check_eq("rst_in_ready_after", 64'(in_ready), 64'd1);

    // Cross-slice carry, 32-bit, 1 stage
    v1_in = 1'b1; a1 = 32'h0000_FFFF; b1 = 32'h0000_0001;
    @(posedge clk); #1;
    v1_in = 1'b0;
    lat = 1;
    while (!v1_out && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("s1_latency", 64'(lat), 64'd1);
    check_eq("s1_sum", 64'(s1), 64'h0001_0000);
    check_eq("s1_flags", 64'({c1, o1, z1}), 64'd0);
    @(posedge clk); #1;

    // Cross-slice carry, 32-bit, 4 stages
    v4_in = 1'b1; a4 = 32'h0000_FFFF; b4 = 32'h0000_0001;
    @(posedge clk); #1;
    v4_in = 1'b0;
    lat = 1;
    while (!v4_out && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("s4_latency", 64'(lat), 64'd4);
    check_eq("s4_sum", 64'(s4), 64'h0001_0000);
    check_eq("s4_flags", 64'({c4, o4, z4}), 64'd0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
